// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: divider state encoding and default operand width.
package arith_pkg;

   localparam int DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage : arith_pkg

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module div_step #(
   parameter int WIDTH = 16
) (
   // Before the shift the partial remainder is always below 2**(WIDTH-1),
   // so only its low WIDTH-1 bits are carried in.
   input  logic [WIDTH-2:0] rem,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH-1:0] trial;
   logic [WIDTH:0]   diff;

   // Widened subtract: the extra MSB is the borrow, i.e. trial < divisor.
   always_comb begin
      trial    = {rem, dvd_bit};
      diff     = {1'b0, trial} - {1'b0, divisor};
      q_bit    = ~diff[WIDTH];
      rem_next = diff[WIDTH] ? trial : diff[WIDTH-1:0];
   end

endmodule : div_step

// File: rtl/divider.sv
// Sequential unsigned divider: one quotient bit per cycle, MSB first,
// with a divide-by-zero shortcut and back-to-back start support.
module divider
   import arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done,
   output logic             busy,
   output logic             div_by_zero
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_t       state;
   // dvd_q shifts left each step: its MSB feeds the step, quotient bits
   // enter at the LSB, so after WIDTH steps it holds the quotient.
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-2:0] rem_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH-1:0] rem_nxt;
   logic             q_bit;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .dvd_bit  (dvd_q[WIDTH-1]),
      .divisor  (dvs_q),
      .rem_next (rem_nxt),
      .q_bit    (q_bit)
   );

   // Control FSM, iteration datapath and registered results.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         done        <= 1'b0;
         busy        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  dvd_q <= dividend;
                  dvs_q <= divisor;
                  rem_q <= '0;
                  cnt_q <= '0;
                  if (divisor == '0) begin
                     // No iterations needed: publish the saturated result now.
                     state       <= DONE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state       <= BUSY;
                     busy        <= 1'b1;
                     div_by_zero <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               rem_q <= rem_nxt[WIDTH-2:0];
               dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_STEP) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= {dvd_q[WIDTH-2:0], q_bit};
                  remainder <= rem_nxt;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule : divider

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus random operands
// compared against plain integer division.
module tb_divider;

   localparam int W = 16;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         done;
   logic         busy;
   logic         div_by_zero;

   int tests = 0;
   int fails = 0;

   divider #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .done        (done),
      .busy        (busy),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   // Advance one clock and settle just after the edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // Issue one operation and wait for done; leaves the bench in the done cycle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      int cnt;
      int nbusy;
      logic [W-1:0] exp_q;
      logic [W-1:0] exp_r;
      exp_q = (b == 0) ? {W{1'b1}} : a / b;
      exp_r = (b == 0) ? a : a % b;
      start = 1'b1; dividend = a; divisor = b;
      cyc();
      start = 1'b0;
      cnt = 1; nbusy = 0;
      while (!done && cnt < 40) begin
         if (busy) nbusy++;
         cyc();
         cnt++;
      end
      check({tag, " done_cycle"}, cnt, (b == 0) ? 1 : W + 1);
      check({tag, " busy_cycles"}, nbusy, (b == 0) ? 0 : W);
      check({tag, " busy_in_done"}, busy, 0);
      check({tag, " quotient"}, quotient, exp_q);
      check({tag, " remainder"}, remainder, exp_r);
      check({tag, " div_by_zero"}, div_by_zero, (b == 0) ? 1 : 0);
   endtask

   // Clock past the done cycle and confirm the pulse was a single cycle.
   task automatic after_done(input string tag);
      cyc();
      check({tag, " done_one_cycle"}, done, 0);
   endtask

   initial begin
      int cnt;
      int saw_done;
      logic [W-1:0] a;
      logic [W-1:0] b;

      // Reset state
      reset = 1'b1;
      cyc(); cyc();
      check("rst quotient", quotient, 0);
      check("rst remainder", remainder, 0);
      check("rst done", done, 0);
      check("rst busy", busy, 0);
      check("rst dbz", div_by_zero, 0);
      reset = 1'b0;
      cyc();

      // Basic cases
      run_op(16'd100, 16'd7, "100/7");
      after_done("100/7");
      check("100/7 hold quotient", quotient, 14);
      run_op(16'hFFFF, 16'd1, "ffff/1");
      after_done("ffff/1");
      run_op(16'd3, 16'd10, "3/10");
      after_done("3/10");

      // Divide by zero then a normal op clears the flag
      run_op(16'd5, 16'd0, "5/0");
      after_done("5/0");
      check("5/0 hold dbz", div_by_zero, 1);
      run_op(16'd9, 16'd3, "9/3");
      after_done("9/3");

      // Start during BUSY is ignored
      start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
      cyc();
      start = 1'b0;
      cnt = 1;
      while (cnt < 5) begin cyc(); cnt++; end
      start = 1'b1; dividend = 16'd50; divisor = 16'd5;
      cyc(); cnt++;
      start = 1'b0; dividend = '0; divisor = '0;
      while (!done && cnt < 40) begin cyc(); cnt++; end
      check("ignored_start done_cycle", cnt, 17);
      check("ignored_start quotient", quotient, 333);
      check("ignored_start remainder", remainder, 1);
      after_done("ignored_start");

      // Reset in the middle of an operation
      start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
      cyc();
      start = 1'b0;
      cnt = 1;
      while (cnt < 8) begin cyc(); cnt++; end
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("midrst quotient", quotient, 0);
      check("midrst remainder", remainder, 0);
      check("midrst done", done, 0);
      check("midrst busy", busy, 0);
      check("midrst dbz", div_by_zero, 0);
      saw_done = 0;
      for (int i = 0; i < 20; i++) begin
         if (done || busy) saw_done = 1;
         cyc();
      end
      check("midrst no_done", saw_done, 0);
      run_op(16'd20, 16'd6, "20/6");
      after_done("20/6");

      // Back-to-back: new start issued in the done cycle
      run_op(16'd1000, 16'd7, "b2b_first");
      run_op(16'd40000, 16'd123, "b2b_40000/123");
      after_done("b2b_40000/123");

      // Random operands, some zero and small divisors
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom);
         case ($urandom_range(0, 3))
            0: b = '0;
            1: b = W'($urandom_range(1, 15));
            default: b = W'($urandom);
         endcase
         run_op(a, b, $sformatf("rand%0d", i));
         if ($urandom_range(0, 1) == 1) after_done($sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_divider

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 SHALL have port clock, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, the operation request, sampled on a rising edge.
REQ-005 SHALL have port dividend, input, WIDTH bits, the unsigned numerator, sampled when start is accepted.
REQ-006 SHALL have port divisor, input, WIDTH bits, the unsigned denominator, sampled when start is accepted.
REQ-007 SHALL have port quotient, output, WIDTH bits, the registered unsigned quotient.
REQ-008 SHALL have port remainder, output, WIDTH bits, the registered unsigned remainder.
REQ-009 SHALL have port done, output, 1 bit, a one-cycle pulse marking that the results are valid.
REQ-010 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-011 SHALL have port div_by_zero, output, 1 bit, a registered flag that is valid with done.

Function
REQ-012 SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-013 SHALL accept start only in IDLE or DONE: on acceptance, latch dividend and divisor, clear the partial remainder, load the iteration counter with 0, and go to BUSY.
REQ-014 SHALL ignore start while in BUSY, with no effect on the latched operands, counter or outputs.
REQ-015 SHALL perform restoring radix-2 division, one quotient bit per BUSY cycle, MSB first.
- Each step forms trial = {partial_rem[WIDTH-2:0], next dividend bit} and compares it with the divisor.
- If trial is greater than or equal to the divisor, the step subtracts the divisor and sets the quotient bit to 1; otherwise it keeps trial and sets the bit to 0.
REQ-016 SHALL use a (WIDTH+1)-bit subtract so the compare never overflows.
REQ-017 SHALL spend exactly WIDTH cycles in BUSY, then go to DONE and register quotient and remainder on that transition.
REQ-018 SHALL assert done in the cycle WIDTH+1 after the start-acceptance cycle (cycle 0); for WIDTH=16 that is cycle 17.
REQ-019 SHALL handle divisor==0 at acceptance by skipping BUSY and going straight to DONE.
- Results: quotient = all ones, remainder = dividend, div_by_zero = 1.
- done is asserted in cycle 1.
REQ-020 SHALL clear div_by_zero on every start acceptance whose divisor is nonzero.
REQ-021 SHALL hold done high for exactly one cycle; DONE goes to IDLE on the next edge unless a new start is accepted.
REQ-022 SHALL hold quotient, remainder and div_by_zero stable from DONE until the next operation completes or reset occurs.
REQ-023 SHALL drive busy high exactly while the state is BUSY.
REQ-024 SHALL accept a start in the DONE cycle, giving back-to-back operations with no idle cycle between them.

Reset
REQ-025 SHALL, on reset, enter IDLE and clear quotient, remainder, done, busy, div_by_zero, the latched operands and the counter to 0.
REQ-026 SHALL give reset priority over start and over any in-flight operation; an interrupted operation produces no done pulse.

Structure
REQ-027 SHALL take the state typedef div_state_t (IDLE, BUSY, DONE) and the constant DIV_WIDTH=16 from the shared package arith_pkg.
REQ-028 SHALL place the single-bit restoring step in one combinational sub-module, div_step, with these ports:
- inputs: partial remainder, dividend bit, divisor;
- outputs: next partial remainder, quotient bit.

Verification
REQ-029 SHALL verify: 100/7 with start in cycle 0 -> quotient=14, remainder=2, done only in cycle 17, busy in cycles 1-16.
REQ-030 SHALL verify: 0xFFFF/1 -> quotient=0xFFFF, remainder=0; and 3/10 -> quotient=0, remainder=3.
REQ-031 SHALL verify: 5/0 -> done in cycle 1, quotient=0xFFFF, remainder=5, div_by_zero=1; a following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-032 SHALL verify: start with 50/5 issued in cycle 5 of an ongoing 1000/3 -> ignored; result quotient=333, remainder=1 in cycle 17.
REQ-033 SHALL verify: reset in cycle 8 of 1000/3 -> all outputs 0 next cycle, no done; a new 20/6 then gives quotient=3, remainder=2.
REQ-034 SHALL verify: start 40000/123 asserted in the DONE cycle of a prior op -> accepted; quotient=325, remainder=25 seventeen cycles later.
